// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared constants and FSM encoding for the Avalon-MM burst slave model.
package avmm_lvds_bridge_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BURSTCNT_W = 8;
    localparam int unsigned MAX_BURST  = 2 ** (BURSTCNT_W - 1);

    // Non-zero seed so the LFSR never locks up in the all-zero state.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_STALL    = 3'd1;
    localparam state_t ST_WR_BURST = 3'd2;
    localparam state_t ST_RD_WAIT  = 3'd3;
    localparam state_t ST_RD_DATA  = 3'd4;

endpackage

// File: rtl/avmm_bp_gen.sv
// Backpressure generator: picks a stall count N per transfer (constant or
// LFSR-random in [min,max]), stalls for N cycles, then pulses accept once.
module avmm_bp_gen
    import avmm_lvds_bridge_pkg::*;
#(
    parameter int unsigned BP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [BP_W-1:0] bp_min_i,
    input  logic [BP_W-1:0] bp_max_i,
    input  logic            bp_rand_i,
    output logic            accept
);

    logic [15:0]   lfsr_q;
    logic          lfsr_fb;
    logic [BP_W:0] span;
    logic [15:0]   divisor;
    logic [15:0]   mod_w;
    logic [BP_W-1:0] n;
    logic [BP_W-1:0] cnt_q;
    logic          active_q;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Stall count for a transfer that has not started stalling yet.
    always_comb begin
        span = {1'b0, bp_max_i} - {1'b0, bp_min_i} + (BP_W + 1)'(1);
        // Divisor forced to 1 when min>max so the unused modulo never divides by zero.
        divisor = (bp_min_i > bp_max_i) ? 16'd1 : 16'(span);
        mod_w   = lfsr_q % divisor;
        if (!bp_rand_i) begin
            n = bp_max_i;
        end else if (bp_min_i > bp_max_i) begin
            n = bp_min_i;
        end else begin
            n = bp_min_i + mod_w[BP_W-1:0];
        end
    end

    assign accept = !reset && req && (active_q ? (cnt_q == '0) : (n == '0));

    // LFSR free-runs; stall counter runs only while a transfer is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            if (req) begin
                if (!active_q) begin
                    if (n != '0) begin
                        active_q <= 1'b1;
                        cnt_q    <= n - BP_W'(1);
                    end
                end else if (cnt_q == '0) begin
                    active_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - BP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/avmm_burst_slave_model.sv
// Avalon-MM burst slave with internal word memory and programmable backpressure.
// Optional byte enables are compiled in with the AVS_BYTEENABLE_EN macro.
module avmm_burst_slave_model
    import avmm_lvds_bridge_pkg::*;
#(
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned BP_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [31:0]           writedata,
    input  logic                  write,
    input  logic                  read,
    input  logic [BURSTCNT_W-1:0] burstcount,
`ifdef AVS_BYTEENABLE_EN
    input  logic [3:0]            byteenable,
`endif
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    input  logic [BP_W-1:0]       bp_min_i,
    input  logic [BP_W-1:0]       bp_max_i,
    input  logic                  bp_rand_i
);

    // Cycles spent in RD_WAIT before the first beat is issued to the RAM.
    localparam int unsigned LAT_LOAD = (RD_LATENCY > 3) ? RD_LATENCY - 3 : 0;

    logic [31:0] mem [2**MEM_AW];

    state_t                state_q, state_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic [BURSTCNT_W-1:0] rem_q, rem_d;
    logic [7:0]            lat_q, lat_d;

    logic                  cmd_phase;
    logic                  req;
    logic                  accept;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [BURSTCNT_W-1:0] bcnt_eff;
    logic [MEM_AW-1:0]     cmd_addr;
    logic [MEM_AW-1:0]     wr_addr;
    logic [MEM_AW-1:0]     rd_addr;
    logic                  rd_issue;
    logic [3:0]            be;

    logic unused_addr;
    assign unused_addr = ^address[ADDR_W-1:MEM_AW];

`ifdef AVS_BYTEENABLE_EN
    assign be = byteenable;
`else
    assign be = 4'hF;
`endif

    assign cmd_addr = address[MEM_AW-1:0];
    assign bcnt_eff = (burstcount == '0) ? BURSTCNT_W'(1) : burstcount;

    // Transfer request presented to the backpressure generator and accept decode.
    always_comb begin
        cmd_phase = (state_q == ST_IDLE) || (state_q == ST_STALL);
        if (cmd_phase) begin
            // Hold off new commands until the final read beat has gone out.
            req = (write || read) && !readdatavalid;
        end else if (state_q == ST_WR_BURST) begin
            req = write;
        end else begin
            req = 1'b0;
        end
        acc_wr   = accept && write;
        acc_rd   = accept && cmd_phase && !write && read;
        wr_addr  = cmd_phase ? cmd_addr : addr_q;
        rd_issue = (state_q == ST_RD_DATA) || (acc_rd && (RD_LATENCY == 1));
        rd_addr  = (state_q == ST_RD_DATA) ? addr_q : cmd_addr;
    end

    avmm_bp_gen #(
        .BP_W (BP_W)
    ) u_bp_gen (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bp_min_i  (bp_min_i),
        .bp_max_i  (bp_max_i),
        .bp_rand_i (bp_rand_i),
        .accept    (accept)
    );

    assign waitrequest = !accept;

    // Burst sequencing: address/beat counters and latency countdown.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE, ST_STALL: begin
                if (acc_wr) begin
                    addr_d  = cmd_addr + MEM_AW'(1);
                    rem_d   = bcnt_eff - BURSTCNT_W'(1);
                    state_d = (bcnt_eff == BURSTCNT_W'(1)) ? ST_IDLE : ST_WR_BURST;
                end else if (acc_rd) begin
                    if (RD_LATENCY == 1) begin
                        // First beat is issued in the accept cycle itself.
                        addr_d  = cmd_addr + MEM_AW'(1);
                        rem_d   = bcnt_eff - BURSTCNT_W'(1);
                        state_d = (bcnt_eff == BURSTCNT_W'(1)) ? ST_IDLE : ST_RD_DATA;
                    end else begin
                        addr_d  = cmd_addr;
                        rem_d   = bcnt_eff;
                        lat_d   = 8'(LAT_LOAD);
                        state_d = (RD_LATENCY == 2) ? ST_RD_DATA : ST_RD_WAIT;
                    end
                end else begin
                    state_d = req ? ST_STALL : ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                if (acc_wr) begin
                    addr_d = addr_q + MEM_AW'(1);
                    rem_d  = rem_q - BURSTCNT_W'(1);
                    if (rem_q == BURSTCNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_RD_DATA;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            ST_RD_DATA: begin
                addr_d = addr_q + MEM_AW'(1);
                rem_d  = rem_q - BURSTCNT_W'(1);
                if (rem_q == BURSTCNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
        end
    end

    // RAM write port with per-byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    // RAM read port feeding the registered read-data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdatavalid <= 1'b0;
            readdata      <= '0;
        end else begin
            readdatavalid <= rd_issue;
            if (rd_issue) begin
                readdata <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_avmm_burst_slave_model.sv
// Bench for avmm_burst_slave_model; reference memory is a plain word array.
module tb_avmm_burst_slave_model;
    import avmm_lvds_bridge_pkg::*;

    localparam int unsigned MEM_AW     = 10;
    localparam int unsigned MEM_WORDS  = 2 ** MEM_AW;
    localparam int unsigned RD_LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic [7:0]  burstcount;
    logic [3:0]  be;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [3:0]  bp_min;
    logic [3:0]  bp_max;
    logic        bp_rand;

    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] wbuf [MAX_BURST];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    avmm_burst_slave_model #(
        .MEM_AW     (MEM_AW),
        .RD_LATENCY (RD_LATENCY),
        .BP_W       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .writedata     (writedata),
        .write         (write),
        .read          (read),
        .burstcount    (burstcount),
`ifdef AVS_BYTEENABLE_EN
        .byteenable    (be),
`endif
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .bp_min_i      (bp_min),
        .bp_max_i      (bp_max),
        .bp_rand_i     (bp_rand)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_write(input int unsigned idx, input logic [31:0] d);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        ref_mem[idx % MEM_WORDS] = (ref_mem[idx % MEM_WORDS] & ~m) | (d & m);
    endtask

    // Counts stall cycles seen before the current request is taken.
    task automatic wait_accept(output int unsigned stalls);
        bit got;
        got    = 1'b0;
        stalls = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (!waitrequest) got = 1'b1;
            else stalls++;
        end
        chk("accept_timeout", 32'(got), 32'd1);
        step();
    endtask

    task automatic wr_burst(input int unsigned addr, input int unsigned bc,
                            input int unsigned lo, input int unsigned hi);
        int unsigned n;
        int unsigned st;
        n          = (bc == 0) ? 1 : bc;
        address    = addr;
        burstcount = 8'(bc);
        write      = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            writedata = wbuf[i];
            wait_accept(st);
            chk("wr_stall_range", 32'(st >= lo && st <= hi), 32'd1);
            ref_write(addr + i, wbuf[i]);
        end
        write = 1'b0;
    endtask

    task automatic rd_burst(input int unsigned addr, input int unsigned bc,
                            input int unsigned lo, input int unsigned hi);
        int unsigned n;
        int unsigned st;
        n          = (bc == 0) ? 1 : bc;
        address    = addr;
        burstcount = 8'(bc);
        read       = 1'b1;
        wait_accept(st);
        chk("rd_stall_range", 32'(st >= lo && st <= hi), 32'd1);
        // read stays asserted as a would-be new command; it must be held off.
        for (int k = 0; k < int'(RD_LATENCY) - 1; k++) begin
            chk("rdv_latency", 32'(readdatavalid), 32'd0);
            chk("rd_outstanding_wr", 32'(waitrequest), 32'd1);
            step();
        end
        for (int unsigned i = 0; i < n; i++) begin
            chk("rdv_beat", 32'(readdatavalid), 32'd1);
            chk("rd_data", readdata, ref_mem[(addr + i) % MEM_WORDS]);
            chk("rd_outstanding_wr", 32'(waitrequest), 32'd1);
            if (i == n - 1) read = 1'b0;
            step();
        end
        chk("rdv_after_burst", 32'(readdatavalid), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned st;
        int unsigned bc;
        int unsigned a;

        reset      = 1'b1;
        address    = '0;
        writedata  = '0;
        write      = 1'b0;
        read       = 1'b0;
        burstcount = '0;
        be         = 4'hF;
        bp_min     = 4'd0;
        bp_max     = 4'd0;
        bp_rand    = 1'b0;

        step();
        step();
        chk("reset_waitrequest", 32'(waitrequest), 32'd1);
        chk("reset_rdv", 32'(readdatavalid), 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        reset = 1'b0;
        step();

        // Zero-wait write and read of four words.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        wr_burst(32'h10, 4, 0, 0);
        rd_burst(32'h10, 4, 0, 0);

        // Constant one-cycle backpressure.
        bp_max = 4'd1;
        wbuf[0] = 32'hDEADBEEF;
        wr_burst(5, 1, 1, 1);
        rd_burst(5, 1, 1, 1);

        // Random mode with min above max collapses to a fixed min stall.
        bp_rand = 1'b1;
        bp_min  = 4'd3;
        bp_max  = 4'd1;
        wbuf[0] = $urandom;
        wr_burst(32'h20, 1, 3, 3);
        rd_burst(32'h20, 1, 3, 3);

        // Random backpressure in [1,7] over random bursts.
        bp_min = 4'd1;
        bp_max = 4'd7;
        for (int b = 0; b < 50; b++) begin
            bc = $urandom_range(MAX_BURST, 1);
            a  = $urandom_range(MEM_WORDS - 1, 0);
            for (int unsigned i = 0; i < bc; i++) wbuf[i] = $urandom;
            wr_burst(a, bc, 1, 7);
            rd_burst(a, bc, 1, 7);
        end

        // Maximum burst wrapping past the top of memory.
        bp_rand = 1'b0;
        bp_min  = 4'd0;
        bp_max  = 4'd0;
        for (int unsigned i = 0; i < MAX_BURST; i++) wbuf[i] = $urandom;
        wr_burst(MEM_WORDS - 2, MAX_BURST, 0, 0);
        rd_burst(MEM_WORDS - 2, MAX_BURST, 0, 0);
        rd_burst(0, 4, 0, 0);

        // burstcount=0 acts as a single beat.
        wbuf[0] = 32'hC0C0_0201;
        wr_burst(32'h201, 1, 0, 0);
        wbuf[0] = 32'hA0A0_0200;
        wr_burst(32'h200, 0, 0, 0);
        wbuf[0] = 32'hB0B0_0300;
        wr_burst(32'h300, 1, 0, 0);
        rd_burst(32'h200, 0, 0, 0);
        rd_burst(32'h201, 1, 0, 0);
        rd_burst(32'h300, 1, 0, 0);

        // Read attempted between beats of a write burst is held off.
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        address    = 32'h40;
        burstcount = 8'd4;
        writedata  = wbuf[0];
        write      = 1'b1;
        wait_accept(st);
        chk("coll_first_beat_stall", st, 32'd0);
        ref_write(32'h40, wbuf[0]);
        write = 1'b0;
        read  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rd_during_wr_burst", 32'(waitrequest), 32'd1);
            step();
        end
        read  = 1'b0;
        write = 1'b1;
        for (int unsigned i = 1; i < 4; i++) begin
            writedata = wbuf[i];
            wait_accept(st);
            ref_write(32'h40 + i, wbuf[i]);
        end
        write = 1'b0;
        rd_burst(32'h40, 4, 0, 0);

        // Simultaneous read and write: write wins, no read data follows.
        address    = 32'h60;
        burstcount = 8'd1;
        writedata  = 32'h1234_5678;
        write      = 1'b1;
        read       = 1'b1;
        wait_accept(st);
        ref_write(32'h60, 32'h1234_5678);
        write = 1'b0;
        read  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("no_rdv_after_write_wins", 32'(readdatavalid), 32'd0);
            step();
        end
        rd_burst(32'h60, 1, 0, 0);

        // Reset in the middle of a read burst.
        address    = 32'h10;
        burstcount = 8'd8;
        read       = 1'b1;
        wait_accept(st);
        read = 1'b0;
        for (int k = 0; k < int'(RD_LATENCY) - 1; k++) step();
        chk("abort_beat0", 32'(readdatavalid), 32'd1);
        step();
        chk("abort_beat1", 32'(readdatavalid), 32'd1);
        reset = 1'b1;
        step();
        chk("abort_rdv", 32'(readdatavalid), 32'd0);
        chk("abort_waitrequest", 32'(waitrequest), 32'd1);
        chk("abort_readdata", readdata, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("abort_no_more_rdv", 32'(readdatavalid), 32'd0);
            step();
        end
        rd_burst(32'h10, 4, 0, 0);

`ifdef AVS_BYTEENABLE_EN
        wbuf[0] = 32'hFFFF_FFFF;
        wr_burst(32'h80, 1, 0, 0);
        be      = 4'b0101;
        wbuf[0] = 32'h0000_0000;
        wr_burst(32'h80, 1, 0, 0);
        be = 4'hF;
        rd_burst(32'h80, 1, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
